// File: rtl/poly_oscillator.sv
// poly_oscillator: multi-voice square-wave oscillator bank.
// Each voice divides clk by (divider << octave) and raises square for the
// first thr counts of every period; a registered popcount of the squares
// feeds the mixer. Optional per-voice duty control: define POLY_OSC_DUTY_EN.
module poly_oscillator #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned DIV_W      = 18,
    parameter int unsigned OCT_W      = 2,
    localparam int unsigned SH_MAX    = (1 << OCT_W) - 1,
    localparam int unsigned CNT_W     = DIV_W + SH_MAX,
    localparam int unsigned SUM_W     = $clog2(NUM_VOICES + 1),
    localparam int unsigned VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                        clk,
    input  logic                        nRst,
    input  logic [NUM_VOICES-1:0]       en,
    input  logic                        wr_en,
    input  logic [VOICE_W-1:0]          wr_voice,
    input  logic [DIV_W-1:0]            wr_divider,
    input  logic [OCT_W-1:0]            wr_octave,
`ifdef POLY_OSC_DUTY_EN
    input  logic [1:0]                  wr_duty,
`endif
    output logic [NUM_VOICES*CNT_W-1:0] count,
    output logic [NUM_VOICES-1:0]       square,
    output logic [NUM_VOICES-1:0]       wrap,
    output logic [SUM_W-1:0]            voice_sum
);

    logic [DIV_W-1:0]      divider_q [NUM_VOICES];
    logic [OCT_W-1:0]      octave_q  [NUM_VOICES];
    logic [CNT_W-1:0]      count_q   [NUM_VOICES];
`ifdef POLY_OSC_DUTY_EN
    logic [1:0]            duty_q    [NUM_VOICES];
`endif
    logic [CNT_W-1:0]      div_c     [NUM_VOICES];
    logic [CNT_W-1:0]      thr_c     [NUM_VOICES];
    logic [CNT_W-1:0]      cnt_nxt_c [NUM_VOICES];
    logic [NUM_VOICES-1:0] square_c;
    logic [NUM_VOICES-1:0] wrap_q;
    logic [SUM_W-1:0]      sum_c;

    // Period register file; out-of-range voice indices match no entry.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                divider_q[v] <= '0;
                octave_q[v]  <= '0;
`ifdef POLY_OSC_DUTY_EN
                duty_q[v]    <= '0;
`endif
            end
        end else begin
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                if (wr_en && (wr_voice == VOICE_W'(v))) begin
                    divider_q[v] <= wr_divider;
                    octave_q[v]  <= wr_octave;
`ifdef POLY_OSC_DUTY_EN
                    duty_q[v]    <= wr_duty;
`endif
                end
            end
        end
    end

    // Divisor, duty threshold, next count and square decode per voice.
    always_comb begin
        square_c = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            div_c[v] = CNT_W'(divider_q[v]) << octave_q[v];
`ifdef POLY_OSC_DUTY_EN
            case (duty_q[v])
                2'd1:    thr_c[v] = div_c[v] >> 2;
                2'd2:    thr_c[v] = div_c[v] >> 3;
                default: thr_c[v] = div_c[v] >> 1;
            endcase
`else
            thr_c[v] = div_c[v] >> 1;
`endif
            // Silence beats wrap; >= catches a divisor lowered under the count.
            if (!en[v] || (div_c[v] == '0)) begin
                cnt_nxt_c[v] = '0;
            end else if (count_q[v] >= div_c[v]) begin
                cnt_nxt_c[v] = CNT_W'(1);
            end else begin
                cnt_nxt_c[v] = count_q[v] + CNT_W'(1);
            end
            square_c[v] = (count_q[v] != '0) && (count_q[v] <= thr_c[v]);
        end
    end

    // Phase counters and wrap flags, which mark every entry into count 1.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                count_q[v] <= '0;
            end
            wrap_q <= '0;
        end else begin
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                count_q[v] <= cnt_nxt_c[v];
                wrap_q[v]  <= (cnt_nxt_c[v] == CNT_W'(1));
            end
        end
    end

    // Popcount of the current square vector.
    always_comb begin
        sum_c = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            sum_c = sum_c + SUM_W'(square_c[v]);
        end
    end

    // Registered voice sum for the mixer.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            voice_sum <= '0;
        end else begin
            voice_sum <= sum_c;
        end
    end

    // Pack the counters onto the flat output bus.
    always_comb begin
        count = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            count[v*CNT_W +: CNT_W] = count_q[v];
        end
    end

    assign square = square_c;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_poly_oscillator.sv
// Bench for poly_oscillator: directed scenarios plus random writes/enables,
// all compared every cycle against a period/threshold model of the voices.
module tb_poly_oscillator;

    localparam int unsigned NV    = 4;
    localparam int unsigned DIV_W = 18;
    localparam int unsigned OCT_W = 2;
    localparam int unsigned CNT_W = DIV_W + (1 << OCT_W) - 1;
    localparam int unsigned SUM_W = 3;

    logic                   clk = 1'b0;
    logic                   nRst;
    logic [NV-1:0]          en;
    logic                   wr_en;
    logic [1:0]             wr_voice;
    logic [DIV_W-1:0]       wr_divider;
    logic [OCT_W-1:0]       wr_octave;
    logic [1:0]             wr_duty;
    logic [NV*CNT_W-1:0]    count;
    logic [NV-1:0]          square;
    logic [NV-1:0]          wrap;
    logic [SUM_W-1:0]       voice_sum;

    int checks = 0;
    int errors = 0;

    // Reference model state: register file and phase of each voice.
    int            m_div  [NV];
    int            m_oct  [NV];
    int            m_duty [NV];
    longint        m_cnt  [NV];
    logic [NV-1:0] m_wrap;
    int            m_sum;

    always #5 clk = ~clk;

    poly_oscillator #(.NUM_VOICES(NV), .DIV_W(DIV_W), .OCT_W(OCT_W)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_voice   (wr_voice),
        .wr_divider (wr_divider),
        .wr_octave  (wr_octave),
`ifdef POLY_OSC_DUTY_EN
        .wr_duty    (wr_duty),
`endif
        .count      (count),
        .square     (square),
        .wrap       (wrap),
        .voice_sum  (voice_sum)
    );

    function automatic longint period(int v);
        return longint'(m_div[v]) * (longint'(1) << m_oct[v]);
    endfunction

    function automatic longint high_len(int v);
        case (m_duty[v])
            1:       return period(v) / 4;
            2:       return period(v) / 8;
            default: return period(v) / 2;
        endcase
    endfunction

    function automatic logic [NV-1:0] exp_square();
        logic [NV-1:0] s;
        for (int v = 0; v < int'(NV); v++)
            s[v] = (m_cnt[v] >= 1) && (m_cnt[v] <= high_len(v));
        return s;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < int'(NV); v++) begin
            m_div[v] = 0; m_oct[v] = 0; m_duty[v] = 0; m_cnt[v] = 0;
        end
        m_wrap = '0;
        m_sum  = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int v = 0; v < int'(NV); v++)
            chk($sformatf("count%0d", v), 64'(count[v*CNT_W +: CNT_W]), 64'(m_cnt[v]));
        chk("square", 64'(square), 64'(exp_square()));
        chk("wrap", 64'(wrap), 64'(m_wrap));
        chk("voice_sum", 64'(voice_sum), 64'(m_sum));
    endtask

    // One clock: advance the model with the inputs held across the edge, then check.
    task automatic tick();
        logic [NV-1:0] sq_before;
        longint d, n;
        sq_before = exp_square();
        @(posedge clk);
        if (nRst) begin
            for (int v = 0; v < int'(NV); v++) begin
                d = period(v);
                if (!en[v] || d == 0)   n = 0;
                else if (m_cnt[v] >= d) n = 1;
                else                    n = m_cnt[v] + 1;
                m_wrap[v] = (n == 1);
                m_cnt[v]  = n;
            end
            if (wr_en && int'(wr_voice) < int'(NV)) begin
                m_div[wr_voice] = int'(wr_divider);
                m_oct[wr_voice] = int'(wr_octave);
`ifdef POLY_OSC_DUTY_EN
                m_duty[wr_voice] = int'(wr_duty);
`endif
            end
            m_sum = $countones(sq_before);
        end
        #1;
        check_all();
    endtask

    task automatic wr(input int v, input int d, input int o, input int du);
        wr_en      = 1'b1;
        wr_voice   = 2'(v);
        wr_divider = DIV_W'(d);
        wr_octave  = OCT_W'(o);
        wr_duty    = 2'(du);
        tick();
        wr_en      = 1'b0;
    endtask

    // Distance in cycles between two successive wrap pulses of voice v.
    task automatic measure_period(input int v, input int exp, input string tag);
        int  n;
        bit  seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (wrap[v]) seen = 1'b1;
        end
        n = 0;
        if (seen) begin
            for (int i = 0; i < 200; i++) begin
                tick();
                n++;
                if (wrap[v]) break;
            end
        end
        chk(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        nRst = 1'b0; en = '0; wr_en = 1'b0; wr_voice = '0;
        wr_divider = '0; wr_octave = '0; wr_duty = '0;
        model_reset();
        #3;
        check_all();
        tick();
        tick();
        nRst = 1'b1;

        // Voice 0: divisor 4, 50 % duty.
        wr(0, 4, 0, 0);
        en = 4'b0001;
        for (int i = 0; i < 12; i++) tick();
        measure_period(0, 4, "v0_period");

        // Voice 1: 5 << 2 = 20.
        wr(1, 5, 2, 0);
        en = 4'b0011;
        measure_period(1, 20, "v1_period");
        for (int i = 0; i < 25; i++) tick();

        // Voice 2: reload divisor 100 -> 40 mid-period.
        wr(2, 100, 0, 0);
        en = 4'b0111;
        for (int i = 0; i < 60; i++) tick();
        chk("v2_at_60", 64'(count[2*CNT_W +: CNT_W]), 64'd60);
        wr(2, 40, 0, 0);
        tick();
        chk("v2_reload_wraps", 64'(count[2*CNT_W +: CNT_W]), 64'd1);
        measure_period(2, 40, "v2_new_period");

        // All voices divisor 2, enabled together: sum alternates 4 / 0.
        en = '0;
        tick();
        for (int v = 0; v < int'(NV); v++) wr(v, 2, 0, 0);
        en = 4'b1111;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k >= 2) chk("sum_alt", 64'(voice_sum), (k % 2 == 0) ? 64'd4 : 64'd0);
        end

        // Silencing: enable drop and divisor 0.
        wr(0, 9, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        en = 4'b1110;
        tick();
        chk("en_drop_count", 64'(count[0 +: CNT_W]), 64'd0);
        chk("en_drop_wrap_sq", 64'({wrap[0], square[0]}), 64'd0);
        wr(1, 0, 0, 0);
        tick();
        chk("div0_count", 64'(count[1*CNT_W +: CNT_W]), 64'd0);

`ifdef POLY_OSC_DUTY_EN
        // Duty 2 (12.5 %) then duty 3 (50 %) on divisor 16.
        en = '0;
        tick();
        wr(3, 16, 0, 2);
        en = 4'b1000;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("duty2_sq", 64'(square[3]), 64'(k <= 2));
        end
        en = '0;
        tick();
        wr(3, 16, 0, 3);
        en = 4'b1000;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("duty3_sq", 64'(square[3]), 64'(k <= 8));
        end
`endif

        // Random writes and enable changes.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) en = NV'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                wr_en      = 1'b1;
                wr_voice   = 2'($urandom_range(0, NV - 1));
                wr_divider = ($urandom_range(0, 9) == 0) ? '0 : DIV_W'($urandom_range(2, 40));
                wr_octave  = OCT_W'($urandom);
                wr_duty    = 2'($urandom);
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        en    = 4'b1111;
        for (int i = 0; i < 5; i++) tick();

        // Asynchronous reset between clock edges.
        #1;
        nRst = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        nRst = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
